// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub datapath.
//   - Default format widths (binary32) and the constants derived from them.
//   - Bit positions of the four exception flags in the flags vector.
//   - Operand classification enum used when unpacking operands.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;

  // Derived constants for the default format; the datapath rebuilds its own
  // copies from its EXP_W/MAN_W parameters.
  localparam int unsigned DEF_BIAS     = (1 << (DEF_EXP_W - 1)) - 1;
  localparam int unsigned DEF_EXP_ONES = (1 << DEF_EXP_W) - 1;
  localparam logic [31:0] DEF_QNAN     = 32'h7FC0_0000;

  // flags = {invalid, overflow, underflow, inexact}
  localparam int unsigned FLAG_NV = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  // Exponent bias for an arbitrary exponent width.
  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
//   vec   : input vector, MSB first
//   count : number of zeros above the most significant set bit (WIDTH if vec == 0)
module fp_lzc #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the highest set bit makes the last assignment.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor, round-to-nearest-even, FTZ.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand beat handshake
//   a, b, sub            : operands; sub=1 computes a-b
//   out_valid / out_ready: result handshake
//   result, flags        : rounded result, {invalid, overflow, underflow, inexact}
// Stages: S1 unpack/classify/align, S2 add/sub + LZC, S3 normalise/round/pack.
// A single global advance signal stalls every stage at once.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  // Aligned significand: hidden bit, fraction, guard, round, sticky.
  localparam int unsigned SW  = MAN_W + 4;
  localparam int unsigned LZW = $clog2(SW + 1);
  // Working exponent: wide enough for +carry and -lz, MSB is the sign.
  localparam int unsigned XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN_PAT = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};

  function automatic fp_class_e classify(input logic [W-2:0] mag);
    if (mag[W-2:MAN_W] == '0) begin
      return ZERO;
    end else if (mag[W-2:MAN_W] == EXP_ONES) begin
      if (mag[MAN_W-1:0] == '0) return INF;
      else if (mag[MAN_W-1])    return QNAN;
      else                      return SNAN;
    end
    return NORM;
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------- S1 comb
  fp_class_e        cls_a, cls_b;
  logic             sign_a, sign_b, swap;
  logic [W-2:0]     mag_a, mag_b, mag_x, mag_y;
  logic [EXP_W-1:0] diff;
  logic [SW-1:0]    x_sig, y_ext, y_shift, y_mask, y_aligned;
  logic             s1_spec;
  logic [W-1:0]     s1_spec_res;
  logic [3:0]       s1_spec_flags;

  always_comb begin
    cls_a  = classify(a[W-2:0]);
    cls_b  = classify(b[W-2:0]);
    sign_a = a[W-1];
    sign_b = b[W-1] ^ sub;
    // FTZ: a zero exponent means the whole magnitude is treated as zero.
    mag_a  = (cls_a == ZERO) ? '0 : a[W-2:0];
    mag_b  = (cls_b == ZERO) ? '0 : b[W-2:0];
    swap   = mag_b > mag_a;
    mag_x  = swap ? mag_b : mag_a;
    mag_y  = swap ? mag_a : mag_b;
    diff   = mag_x[W-2:MAN_W] - mag_y[W-2:MAN_W];
    x_sig  = {|mag_x[W-2:MAN_W], mag_x[MAN_W-1:0], 3'b000};
    y_ext  = {|mag_y[W-2:MAN_W], mag_y[MAN_W-1:0], 3'b000};

    y_shift = y_ext >> diff;
    y_mask  = ~({SW{1'b1}} << diff);
    if (32'(diff) >= MAN_W + 3) begin
      y_aligned = {{(SW - 1){1'b0}}, |y_ext};
    end else begin
      y_aligned = {y_shift[SW-1:1], y_shift[0] | (|(y_ext & y_mask))};
    end

    s1_spec       = 1'b1;
    s1_spec_res   = QNAN_PAT;
    s1_spec_flags = '0;
    if (cls_a inside {QNAN, SNAN} || cls_b inside {QNAN, SNAN}) begin
      s1_spec_flags[FLAG_NV] = (cls_a == SNAN) || (cls_b == SNAN);
    end else if (cls_a == INF && cls_b == INF && sign_a != sign_b) begin
      s1_spec_flags[FLAG_NV] = 1'b1;
    end else if (cls_a == INF) begin
      s1_spec_res = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
    end else if (cls_b == INF) begin
      s1_spec_res = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      s1_spec = 1'b0;
    end
  end

  // ---------------------------------------------------------------- S1 regs
  logic             v1, spec1, sign1, zsign1, esub1;
  logic [W-1:0]     spec_res1;
  logic [3:0]       spec_flags1;
  logic [EXP_W-1:0] exp1;
  logic [SW-1:0]    sigx1, sigy1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      spec1       <= 1'b0;
      spec_res1   <= '0;
      spec_flags1 <= '0;
      sign1       <= 1'b0;
      zsign1      <= 1'b0;
      esub1       <= 1'b0;
      exp1        <= '0;
      sigx1       <= '0;
      sigy1       <= '0;
    end else if (advance) begin
      v1          <= in_valid;
      spec1       <= s1_spec;
      spec_res1   <= s1_spec_res;
      spec_flags1 <= s1_spec_flags;
      sign1       <= swap ? sign_b : sign_a;
      // An exact-zero sum is -0 only when both effective signs are negative.
      zsign1      <= sign_a & sign_b;
      esub1       <= sign_a ^ sign_b;
      exp1        <= mag_x[W-2:MAN_W];
      sigx1       <= x_sig;
      sigy1       <= y_aligned;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [SW:0]      s2_sum;
  logic [LZW-1:0]   s2_lz;

  // |x| >= |y| so the difference never goes negative.
  assign s2_sum = esub1 ? ({1'b0, sigx1} - {1'b0, sigy1}) : ({1'b0, sigx1} + {1'b0, sigy1});

  fp_lzc #(
    .WIDTH(SW),
    .CNT_W(LZW)
  ) u_lzc (
    .vec  (s2_sum[SW-1:0]),
    .count(s2_lz)
  );

  logic             v2, spec2, sign2, zsign2;
  logic [W-1:0]     spec_res2;
  logic [3:0]       spec_flags2;
  logic [EXP_W-1:0] exp2;
  logic [SW:0]      sum2;
  logic [LZW-1:0]   lz2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2          <= 1'b0;
      spec2       <= 1'b0;
      spec_res2   <= '0;
      spec_flags2 <= '0;
      sign2       <= 1'b0;
      zsign2      <= 1'b0;
      exp2        <= '0;
      sum2        <= '0;
      lz2         <= '0;
    end else if (advance) begin
      v2          <= v1;
      spec2       <= spec1;
      spec_res2   <= spec_res1;
      spec_flags2 <= spec_flags1;
      sign2       <= sign1;
      zsign2      <= zsign1;
      exp2        <= exp1;
      sum2        <= s2_sum;
      lz2         <= s2_lz;
    end
  end

  // ---------------------------------------------------------------- S3 comb
  logic [SW-1:0]    norm;
  logic [XW-1:0]    exp_n, exp_f;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_f;
  logic             round_up, inexact;
  logic [W-1:0]     s3_res;
  logic [3:0]       s3_flags;

  always_comb begin
    exp_n = XW'(exp2);
    if (sum2[SW]) begin
      // Carry out: shift right one, folding the dropped bit into sticky.
      norm  = {sum2[SW:2], sum2[1] | sum2[0]};
      exp_n = exp_n + XW'(1);
    end else begin
      norm  = sum2[SW-1:0] << lz2;
      exp_n = exp_n - XW'(lz2);
    end

    inexact  = |norm[2:0];
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[SW-1:3]} + (MAN_W + 2)'(round_up);
    exp_f    = mant_r[MAN_W+1] ? exp_n + XW'(1) : exp_n;
    frac_f   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

    s3_flags = '0;
    if (spec2) begin
      s3_res   = spec_res2;
      s3_flags = spec_flags2;
    end else if (sum2 == '0) begin
      s3_res = {zsign2, {(W - 1){1'b0}}};
    end else if (exp_f[XW-1] || exp_f == '0) begin
      // Below min normal (exp_f is two's complement): flush to signed zero.
      s3_res             = {sign2, {(W - 1){1'b0}}};
      s3_flags[FLAG_UF]  = 1'b1;
      s3_flags[FLAG_NX]  = 1'b1;
    end else if (exp_f >= XW'(EXP_ONES)) begin
      s3_res             = {sign2, EXP_ONES, {MAN_W{1'b0}}};
      s3_flags[FLAG_OF]  = 1'b1;
      s3_flags[FLAG_NX]  = 1'b1;
    end else begin
      s3_res             = {sign2, exp_f[EXP_W-1:0], frac_f};
      s3_flags[FLAG_NX]  = inexact;
    end
  end

  // ---------------------------------------------------------------- S3 regs
  logic         v3;
  logic [W-1:0] result_q;
  logic [3:0]   flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3       <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (advance) begin
      v3       <= v2;
      result_q <= s3_res;
      flags_q  <= s3_flags;
    end
  end

  assign out_valid = v3;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        in_valid_h, in_ready_h, sub_h, out_valid_h, out_ready_h;
  logic [15:0] a_h, b_h, result_h;
  logic [3:0]  flags_h;

  fp_addsub_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  fp_addsub_pipe #(
    .EXP_W(5),
    .MAN_W(10)
  ) dut_h (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid_h),
    .in_ready (in_ready_h),
    .a        (a_h),
    .b        (b_h),
    .sub      (sub_h),
    .out_valid(out_valid_h),
    .out_ready(out_ready_h),
    .result   (result_h),
    .flags    (flags_h)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t        vecs[$];
  logic [35:0] sb[$];

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                              input logic [31:0] vr, input logic [3:0] vf);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vs; v.res = vr; v.fl = vf;
    return v;
  endfunction

  task automatic build_vectors();
    vecs.push_back(mk(32'h443CB6A8, 32'h447D37F0, 1'b0, 32'h44DCF74C, 4'h0));
    vecs.push_back(mk(32'h431A399A, 32'h431A43D7, 1'b1, 32'hBD23D000, 4'h0));
    vecs.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1));
    vecs.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1));
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0));
    vecs.push_back(mk(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'h0));
    vecs.push_back(mk(32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'h0));
    vecs.push_back(mk(32'h40400000, 32'h40800000, 1'b0, 32'h40E00000, 4'h0));
    // specials and boundaries
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0));
    vecs.push_back(mk(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0));
    vecs.push_back(mk(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0));
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0));
    vecs.push_back(mk(32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8));
    vecs.push_back(mk(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0));
    vecs.push_back(mk(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0));
    vecs.push_back(mk(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0));
    vecs.push_back(mk(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'h3));
    vecs.push_back(mk(32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 4'h1));
    vecs.push_back(mk(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'h1));
    vecs.push_back(mk(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b result=%h flags=%h, want 0/0/0",
               out_valid, result, flags);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    int n = 0;
    logic [35:0] exp;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b; sub = vecs[0].sub;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept: in_ready=%b want 1", in_ready);
    end
    sb.push_back({vecs[0].res, vecs[0].fl});
    for (int k = 1; k <= 8 && n == 0; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) n = k;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency: out_valid after %0d cycles, want 3", n);
    end
    exp = sb.pop_front();
    checks++;
    if ({result, flags} !== exp) begin
      errors++;
      $display("FAIL latency_value: got %h/%h want %h/%h", result, flags, exp[35:4], exp[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    logic [35:0] exp;
    out_ready = 1'b1;
    sb.delete();
    while (got < vecs.size() && cyc < 500) begin
      @(negedge clk);
      in_valid = (sent < vecs.size());
      if (in_valid) begin
        a = vecs[sent].a; b = vecs[sent].b; sub = vecs[sent].sub;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result %h", result);
        end else begin
          exp = sb.pop_front();
          if ({result, flags} !== exp) begin
            errors++;
            $display("FAIL b2b_vec%0d: got %h/%h want %h/%h", got, result, flags,
                     exp[35:4], exp[3:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({vecs[sent].res, vecs[sent].fl});
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != vecs.size() || cyc != vecs.size() + 3) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d results in %0d cycles, want %0d in %0d",
               got, cyc, vecs.size(), vecs.size() + 3);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, cyc = 0;
    logic        stalled = 1'b0;
    logic [35:0] held = '0, exp;
    logic [3:0]  pat = 4'b1001;  // cycle 0..3: 1,0,0,1
    sb.delete();
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      if (in_valid) begin
        a = vecs[sent].a; b = vecs[sent].b; sub = vecs[sent].sub;
      end
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready: cyc %0d in_ready=%b out_valid=%b out_ready=%b",
                 cyc, in_ready, out_valid, out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || {result, flags} !== held) begin
          errors++;
          $display("FAIL bp_stable: cyc %0d got %b %h/%h want 1 %h/%h", cyc, out_valid,
                   result, flags, held[35:4], held[3:0]);
        end
      end
      stalled = out_valid && !out_ready;
      held    = {result, flags};
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: unexpected result %h", result);
        end else begin
          exp = sb.pop_front();
          if ({result, flags} !== exp) begin
            errors++;
            $display("FAIL bp_order%0d: got %h/%h want %h/%h", got, result, flags,
                     exp[35:4], exp[3:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({vecs[sent].res, vecs[sent].fl});
        sent++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (got != 8 || sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got %0d left %0d out_valid=%b, want 8 0 0",
               got, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, stale = 0;
    logic [35:0] exp;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b result=%h flags=%h, want 0/0/0",
               out_valid, result, flags);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL reset_stale: out_valid seen in %0d cycles, want 0", stale);
    end
    @(negedge clk);
    in_valid = 1'b1; a = vecs[4].a; b = vecs[4].b; sub = vecs[4].sub;
    #1;
    if (in_ready) sb.push_back({vecs[4].res, vecs[4].fl});
    for (int k = 1; k <= 8 && n == 0; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) n = k;
    end
    checks++;
    if (n != 3 || sb.size() != 1) begin
      errors++;
      $display("FAIL reset_relatency: latency %0d queued %0d, want 3 1", n, sb.size());
    end else begin
      exp = sb.pop_front();
      checks++;
      if ({result, flags} !== exp) begin
        errors++;
        $display("FAIL reset_next: got %h/%h want %h/%h", result, flags, exp[35:4], exp[3:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_half();
    logic [15:0] ha[3] = '{16'h3C00, 16'h3C00, 16'h7BFF};
    logic [15:0] hb[3] = '{16'h3C00, 16'h3C00, 16'h7BFF};
    logic        hs[3] = '{1'b0, 1'b1, 1'b0};
    logic [19:0] hexp[3] = '{{16'h4000, 4'h0}, {16'h0000, 4'h0}, {16'h7C00, 4'h5}};
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      @(negedge clk);
      in_valid_h = 1'b1; a_h = ha[i]; b_h = hb[i]; sub_h = hs[i];
      #1;
      checks++;
      if (in_ready_h !== 1'b1) begin
        errors++;
        $display("FAIL half_ready%0d: in_ready=%b want 1", i, in_ready_h);
      end
      for (int k = 1; k <= 8 && n == 0; k++) begin
        @(negedge clk);
        in_valid_h = 1'b0;
        #1;
        if (out_valid_h) n = k;
      end
      checks++;
      if (n != 3 || {result_h, flags_h} !== hexp[i]) begin
        errors++;
        $display("FAIL half%0d: latency %0d got %h/%h want 3 %h/%h", i, n, result_h, flags_h,
                 hexp[i][19:4], hexp[i][3:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    in_valid_h = 1'b0; out_ready_h = 1'b1; a_h = '0; b_h = '0; sub_h = 1'b0;
    build_vectors();
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_half();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with a valid/ready stream interface, round-to-nearest-even and exception flags. It is the sequential successor to the team's combinational single-precision add/sub unit and is the add path of the floating-point ALU datapath. Format width is set by exponent and mantissa parameters; defaults give binary32.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2)
- W, 1+EXP_W+MAN_W, derived operand width (localparam, not overridable)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  W  operand A
- b  in  W  operand B
- sub  in  1  0: a+b, 1: a−b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  rounded result
- flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Beat accepted when in_valid && in_ready. Result returned in acceptance order.
- Effective b sign = b.sign ^ sub.
- Subnormal inputs are flushed to signed zero (FTZ). Results below min normal are flushed to signed zero with underflow=1, inexact=1.
- Special cases, in priority order:
  - Either operand NaN gives canonical qNaN: sign 0, exp all-ones, fraction MSB only set. invalid=1 only for signalling-NaN inputs.
  - +Inf + −Inf (effective) gives canonical qNaN, invalid=1.
  - Any other Inf gives that Inf, no flags.
- Finite path:
  - Swap so |A| ≥ |B|.
  - Align B right by the exponent difference, keeping guard, round and sticky bits. Difference ≥ MAN_W+3 collapses B into sticky.
  - Add or subtract the significands. Normalise: right-shift 1 on carry; otherwise left-shift by leading-zero count.
  - Round to nearest, ties to even. Renormalise on rounding carry.
- Exact-zero result is +0, except (−0)+(−0) and (−0)−(+0), which give −0.
- Exponent ≥ all-ones after rounding gives signed Inf, overflow=1, inexact=1.
- inexact=1 whenever guard|round|sticky ≠ 0 before rounding.

## Timing
- Three register stages: S1 unpack, classify and align; S2 add/sub and leading-zero count; S3 normalise, round and pack.
- Latency is 3 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Global stall: advance = !out_valid || out_ready. in_ready = advance. All stages hold when advance=0.
- Bubbles propagate. Stage valid bits shift with advance.
- result and flags remain stable while out_valid && !out_ready.
- Reset clears all stage valids, out_valid=0, result=0, flags=0. Beats in flight are discarded.
- After reset deassertion, in_ready=1 on the first clock.
- A beat accepted in the same cycle the output is consumed is not lost.

## Structure
- Package fp_pkg holds:
  - EXP_W/MAN_W-derived constants: bias, exponent all-ones, canonical qNaN pattern.
  - Flag bit indices.
  - Operand-class enum: ZERO, NORM, INF, QNAN, SNAN.
- Sub-module fp_lzc: a parametrised leading-zero counter over MAN_W+4 bits, instantiated in S2.
- The rest of the block is a single module.

## Test plan
- 0x443CB6A8 + 0x447D37F0, sub=0 → 0x44DCF74C, flags 0, out_valid exactly 3 cycles after acceptance.
- 0x431A399A − 0x431A43D7, sub=1 → 0xBD23D000, flags 0. This exercises the 12-bit left normalise.
- 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1. Also 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- Special cases:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Backpressure:
  - Stream 8 back-to-back beats while out_ready toggles 1,0,0,1…
  - Expected: all 8 results in order, none dropped or duplicated, result stable during stalls, in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-operation:
  - Assert rst with 3 beats in flight.
  - Expected: out_valid=0 and result=0 immediately. No stale result after release. The next beat emerges with latency 3.
  - Repeat the first scenario with EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000.
